// File: rtl/iomem_arbiter.sv
// iomem_arbiter: two-master round-robin arbiter for the iomem peripheral bus.
// Shares one slave-side iomem port between master 0 (CPU) and master 1 (e.g. DMA).
// A watchdog force-completes any transfer the slave never acknowledges, returning
// ERR_DATA and pulsing timeout_err, so an absent device cannot stall a master.
//
// Ports:
//   clk, resetn                     clock, synchronous active-low reset
//   m0_* / m1_*                     master ports: valid/wstrb/addr/wdata in, ready/rdata out
//   s_valid/s_wstrb/s_addr/s_wdata  request forwarded from the granted master
//   s_ready/s_rdata                 slave acknowledge and read data
//   grant                           one-hot owner {m1,m0}; 00 when idle
//   timeout_err                     1-cycle pulse when the watchdog fires
//   timeout_addr                    address of the most recent timed-out transfer (sticky)
module iomem_arbiter #(
  parameter int unsigned TIMEOUT  = 255,
  parameter int unsigned TW       = 8,
  parameter logic [31:0] ERR_DATA = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        m0_valid,
  input  logic [3:0]  m0_wstrb,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  input  logic [3:0]  m1_wstrb,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  output logic [3:0]  s_wstrb,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,
  output logic [1:0]  grant,
  output logic        timeout_err,
  output logic [31:0] timeout_addr
);

  localparam logic [TW-1:0] WD_LAST = TW'(TIMEOUT - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state_q, state_d;
  logic [1:0]    grant_q, grant_d;
  logic          last_q, last_d;        // 1: master 1 won the last arbitration
  logic [TW-1:0] wd_cnt_q, wd_cnt_d;
  logic [31:0]   timeout_addr_q, timeout_addr_d;

  logic          sel_m1;
  logic          g_valid;
  logic          win_m1;
  logic          done;
  logic [31:0]   done_rdata;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q        <= IDLE;
      grant_q        <= '0;
      last_q         <= 1'b1;
      wd_cnt_q       <= '0;
      timeout_addr_q <= '0;
    end else begin
      state_q        <= state_d;
      grant_q        <= grant_d;
      last_q         <= last_d;
      wd_cnt_q       <= wd_cnt_d;
      timeout_addr_q <= timeout_addr_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    last_d         = last_q;
    wd_cnt_d       = wd_cnt_q;
    timeout_addr_d = timeout_addr_q;
    s_valid        = 1'b0;
    s_wstrb        = '0;
    s_addr         = '0;
    s_wdata        = '0;
    grant          = '0;
    timeout_err    = 1'b0;
    done           = 1'b0;
    done_rdata     = '0;
    sel_m1         = grant_q[1];
    g_valid        = sel_m1 ? m1_valid : m0_valid;
    // On contention the master that did not win last time takes the bus.
    win_m1         = m1_valid && (!m0_valid || !last_q);

    case (state_q)
      IDLE: begin
        if (m0_valid || m1_valid) begin
          grant_d  = win_m1 ? 2'b10 : 2'b01;
          last_d   = win_m1;
          wd_cnt_d = '0;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        s_valid = 1'b1;
        grant   = grant_q;
        s_wstrb = sel_m1 ? m1_wstrb : m0_wstrb;
        s_addr  = sel_m1 ? m1_addr  : m0_addr;
        s_wdata = sel_m1 ? m1_wdata : m0_wdata;
        if (!g_valid) begin
          // Master abandoned its request: release the bus quietly.
          state_d = IDLE;
        end else if (s_ready) begin
          done       = 1'b1;
          done_rdata = s_rdata;
          state_d    = IDLE;
        end else if (wd_cnt_q == WD_LAST) begin
          done           = 1'b1;
          done_rdata     = ERR_DATA;
          timeout_err    = 1'b1;
          timeout_addr_d = sel_m1 ? m1_addr : m0_addr;
          state_d        = IDLE;
        end else begin
          wd_cnt_d = wd_cnt_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    m0_ready = done && !sel_m1;
    m1_ready = done &&  sel_m1;
    m0_rdata = m0_ready ? done_rdata : '0;
    m1_rdata = m1_ready ? done_rdata : '0;
  end

  assign timeout_addr = timeout_addr_q;

endmodule

// File: tb/tb_iomem_arbiter.sv
// tb_iomem_arbiter: directed bench for iomem_arbiter with a transaction-level
// reference model (owner / age-in-cycles / last winner) checked every cycle,
// plus literal expectations for each scenario.
module tb_iomem_arbiter;

  localparam int TO = 255;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        m0_valid = 1'b0, m1_valid = 1'b0;
  logic [3:0]  m0_wstrb = '0, m1_wstrb = '0;
  logic [31:0] m0_addr = '0, m1_addr = '0, m0_wdata = '0, m1_wdata = '0;
  logic        m0_ready, m1_ready;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_valid;
  logic [3:0]  s_wstrb;
  logic [31:0] s_addr, s_wdata;
  logic        s_ready = 1'b0;
  logic [31:0] s_rdata = '0;
  logic [1:0]  grant;
  logic        timeout_err;
  logic [31:0] timeout_addr;

  always #5 clk = ~clk;

  iomem_arbiter #(.TIMEOUT(TO), .TW(8), .ERR_DATA(32'hFFFF_FFFF)) dut (
    .clk(clk), .resetn(resetn),
    .m0_valid(m0_valid), .m0_wstrb(m0_wstrb), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_wstrb(m1_wstrb), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_wstrb(s_wstrb), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_ready(s_ready), .s_rdata(s_rdata),
    .grant(grant), .timeout_err(timeout_err), .timeout_addr(timeout_addr)
  );

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int          owner = -1;   // -1 idle, else index of master holding the bus
  int          age = 0;      // BUSY cycles elapsed in current transfer, 1-based
  int          last_w = 1;
  logic [31:0] to_addr_m = '0;

  function automatic int pick(input logic v0, input logic v1, input int lw);
    if (v0 && v1) return (lw == 0) ? 1 : 0;
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  function automatic logic m_req();
    return (owner == 0) ? m0_valid : ((owner == 1) ? m1_valid : 1'b0);
  endfunction

  function automatic logic fin_ok();
    return (owner >= 0) && m_req() && s_ready;
  endfunction

  function automatic logic fin_to();
    return (owner >= 0) && m_req() && !s_ready && (age == TO);
  endfunction

  function automatic logic exp_ready(input int m);
    return (owner == m) && (fin_ok() || fin_to());
  endfunction

  function automatic logic [31:0] exp_rdata(input int m);
    if (owner == m && fin_ok()) return s_rdata;
    if (owner == m && fin_to()) return 32'hFFFF_FFFF;
    return 32'h0;
  endfunction

  always @(posedge clk) begin
    if (!resetn) begin
      owner     <= -1;
      age       <= 0;
      last_w    <= 1;
      to_addr_m <= '0;
    end else if (owner < 0) begin
      if (pick(m0_valid, m1_valid, last_w) >= 0) begin
        owner  <= pick(m0_valid, m1_valid, last_w);
        last_w <= pick(m0_valid, m1_valid, last_w);
        age    <= 1;
      end
    end else if (!m_req() || s_ready) begin
      owner <= -1;
    end else if (age == TO) begin
      to_addr_m <= (owner == 0) ? m0_addr : m1_addr;
      owner     <= -1;
    end else begin
      age <= age + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("grant", {30'b0, grant}, (owner == 0) ? 32'd1 : ((owner == 1) ? 32'd2 : 32'd0));
      check("s_valid", {31'b0, s_valid}, {31'b0, owner >= 0});
      check("m0_ready", {31'b0, m0_ready}, {31'b0, exp_ready(0)});
      check("m1_ready", {31'b0, m1_ready}, {31'b0, exp_ready(1)});
      check("m0_rdata", m0_rdata, exp_rdata(0));
      check("m1_rdata", m1_rdata, exp_rdata(1));
      check("timeout_err", {31'b0, timeout_err}, {31'b0, fin_to()});
      check("timeout_addr", timeout_addr, to_addr_m);
      if (owner >= 0) begin
        check("s_addr", s_addr, (owner == 0) ? m0_addr : m1_addr);
        check("s_wdata", s_wdata, (owner == 0) ? m0_wdata : m1_wdata);
        check("s_wstrb", {28'b0, s_wstrb}, {28'b0, (owner == 0) ? m0_wstrb : m1_wstrb});
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn   = 1'b0;
    m0_valid = 1'b0;
    m1_valid = 1'b0;
    s_ready  = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL global_timeout: simulation did not finish, tests=%0d", tests);
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "bench timeout");
  end

  initial begin : main
    bit          seen;
    int          n;
    logic [31:0] rd_cap;
    logic        te_cap;

    do_reset();
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_grant", {30'b0, grant}, 32'd0);
    check("rst_s_valid", {31'b0, s_valid}, 32'd0);
    check("rst_timeout_addr", timeout_addr, 32'd0);
    check("rst_timeout_err", {31'b0, timeout_err}, 32'd0);

    // 1: single m0 read, zero-wait slave
    tick();
    m0_valid = 1'b1; m0_addr = 32'h0300_0000; m0_wstrb = 4'h0;
    s_ready = 1'b1; s_rdata = 32'h0000_00A5;
    @(negedge clk);
    check("t1_req_cycle_s_valid", {31'b0, s_valid}, 32'd0);
    tick();
    @(negedge clk);
    check("t1_m0_ready", {31'b0, m0_ready}, 32'd1);
    check("t1_m0_rdata", m0_rdata, 32'h0000_00A5);
    check("t1_grant", {30'b0, grant}, 32'd1);
    tick();
    m0_valid = 1'b0; s_ready = 1'b0;
    @(negedge clk);
    check("t1_gap_grant", {30'b0, grant}, 32'd0);

    // 2: contention after reset, alternation
    do_reset();
    m0_valid = 1'b1; m1_valid = 1'b1;
    m0_addr = 32'h0300_0100; m1_addr = 32'h0400_0200;
    s_ready = 1'b1; s_rdata = 32'h0000_0011;
    @(negedge clk);
    check("t2_idle_grant", {30'b0, grant}, 32'd0);
    tick();
    @(negedge clk);
    check("t2_first_grant", {30'b0, grant}, 32'd1);
    tick();
    m0_valid = 1'b0;
    @(negedge clk);
    check("t2_gap_grant", {30'b0, grant}, 32'd0);
    tick();
    @(negedge clk);
    check("t2_second_grant", {30'b0, grant}, 32'd2);
    check("t2_m1_rdata", m1_rdata, 32'h0000_0011);
    tick();
    m0_valid = 1'b1;
    tick();
    @(negedge clk);
    check("t2_repeat_grant", {30'b0, grant}, 32'd1);
    tick();
    m0_valid = 1'b0;
    tick();
    @(negedge clk);
    check("t2_repeat_m1_grant", {30'b0, grant}, 32'd2);
    tick();
    m1_valid = 1'b0; s_ready = 1'b0;

    // 3: m1 write with 3 wait states, m0 arrives mid-transfer
    tick();
    m1_valid = 1'b1; m1_addr = 32'h0700_0004; m1_wdata = 32'h1234_5678; m1_wstrb = 4'hF;
    tick();
    m0_valid = 1'b1; m0_addr = 32'h0300_0040; m0_wstrb = 4'h0;
    @(negedge clk);
    check("t3_grant", {30'b0, grant}, 32'd2);
    for (int c = 1; c <= 4; c++) begin
      if (c > 1) begin
        tick();
        if (c == 4) begin s_ready = 1'b1; s_rdata = 32'hDEAD_0000; end
        @(negedge clk);
      end
      check("t3_s_addr", s_addr, 32'h0700_0004);
      check("t3_s_wdata", s_wdata, 32'h1234_5678);
      check("t3_s_wstrb", {28'b0, s_wstrb}, 32'hF);
      check("t3_m1_ready", {31'b0, m1_ready}, {31'b0, c == 4});
      check("t3_m0_waits", {31'b0, m0_ready}, 32'd0);
    end
    tick();
    m1_valid = 1'b0; s_ready = 1'b0;
    @(negedge clk);
    check("t3_gap_grant", {30'b0, grant}, 32'd0);
    tick();
    s_ready = 1'b1; s_rdata = 32'h0000_0077;
    @(negedge clk);
    check("t3_m0_grant", {30'b0, grant}, 32'd1);
    check("t3_m0_rdata", m0_rdata, 32'h0000_0077);
    tick();
    m0_valid = 1'b0; s_ready = 1'b0;

    // 4: watchdog timeout
    tick();
    m0_valid = 1'b1; m0_addr = 32'h0600_0010; m0_wstrb = 4'h0;
    seen = 1'b0; n = 0; rd_cap = '0; te_cap = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      tick();
      @(negedge clk);
      if (m0_ready === 1'b1) begin
        seen = 1'b1; n = i + 1; rd_cap = m0_rdata; te_cap = timeout_err;
      end
    end
    check("t4_ready_seen", {31'b0, seen}, 32'd1);
    check("t4_busy_cycles", n, 32'd255);
    check("t4_err_rdata", rd_cap, 32'hFFFF_FFFF);
    check("t4_timeout_err", {31'b0, te_cap}, 32'd1);
    tick();
    m0_valid = 1'b0;
    @(negedge clk);
    check("t4_err_pulse_end", {31'b0, timeout_err}, 32'd0);
    check("t4_timeout_addr", timeout_addr, 32'h0600_0010);

    // 5: s_ready on the last permitted cycle wins over the watchdog
    tick();
    m0_valid = 1'b1; m0_addr = 32'h0600_0020;
    for (int i = 1; i <= TO; i++) begin
      tick();
      if (i == TO) begin s_ready = 1'b1; s_rdata = 32'hCAFE_F00D; end
    end
    @(negedge clk);
    check("t5_m0_ready", {31'b0, m0_ready}, 32'd1);
    check("t5_m0_rdata", m0_rdata, 32'hCAFE_F00D);
    check("t5_no_err", {31'b0, timeout_err}, 32'd0);
    tick();
    m0_valid = 1'b0; s_ready = 1'b0;
    @(negedge clk);
    check("t5_timeout_addr_sticky", timeout_addr, 32'h0600_0010);

    // 6: reset mid-transfer, held m1 request is re-granted
    tick();
    m1_valid = 1'b1; m1_addr = 32'h0500_0008; m1_wstrb = 4'h0;
    tick();
    tick();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    @(negedge clk);
    check("t6_s_valid", {31'b0, s_valid}, 32'd0);
    check("t6_grant", {30'b0, grant}, 32'd0);
    check("t6_timeout_addr", timeout_addr, 32'd0);
    check("t6_m1_ready", {31'b0, m1_ready}, 32'd0);
    tick();
    @(negedge clk);
    check("t6_regrant", {30'b0, grant}, 32'd2);
    tick();
    s_ready = 1'b1; s_rdata = 32'h0000_0066;
    @(negedge clk);
    check("t6_m1_rdata", m1_rdata, 32'h0000_0066);
    tick();
    m1_valid = 1'b0; s_ready = 1'b0;

    // 7: granted master withdraws its request
    tick();
    m0_valid = 1'b1; m0_addr = 32'h0300_0080;
    tick();
    tick();
    m0_valid = 1'b0;
    @(negedge clk);
    check("t7_no_ready", {31'b0, m0_ready}, 32'd0);
    tick();
    @(negedge clk);
    check("t7_released", {31'b0, s_valid}, 32'd0);
    check("t7_no_err", {31'b0, timeout_err}, 32'd0);

    tick();
    tick();
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
